// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI burst controller and its FIFOs.
package spi_ctrl_pkg;

    localparam int BYTE_W           = 8;
    localparam int CNT_W            = 8;
    localparam int SS_SETUP_DEFAULT = 2;
    localparam int SS_HOLD_DEFAULT  = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WAIT_TX = 3'd2,
        XFER    = 3'd3,
        HOLD    = 3'd4
    } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Show-ahead synchronous FIFO; a pop in the same cycle frees room for a push,
// so a full FIFO that is popped and pushed together keeps its occupancy.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // The extra pointer bit tells full from empty when the indices match.
    assign empty_o   = (r_wr_ptr == r_rd_ptr);
    assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst controller in front of an SPI master: TX/RX byte FIFOs, slave-select
// framing with setup/hold spacing, and the din/start/ready/done handshake.
module spi_burst_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int SS_SETUP = SS_SETUP_DEFAULT,
    parameter int SS_HOLD  = SS_HOLD_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    output logic              tx_full_o,
    input  logic              rd_en_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic              rx_empty_o,
    input  logic              go_i,
    input  logic [BYTE_W-1:0] len_i,
    output logic              busy_o,
    output logic              burst_done_o,
    output logic              rx_ovf_o,
    output logic [BYTE_W-1:0] spi_din_o,
    output logic              spi_start_o,
    input  logic              spi_ready_i,
    input  logic              spi_done_tick_i,
    input  logic [BYTE_W-1:0] spi_dout_i,
    output logic              ss_n_o
);

    state_t            r_state, w_next_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [BYTE_W-1:0] r_rem, w_rem_nxt;
    logic              r_ss_n, w_ss_n_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_ovf, w_ovf_nxt;
    logic [BYTE_W-1:0] r_din, w_din_nxt;
    logic              r_start, w_start_nxt;

    logic              w_tx_pop;
    logic              w_tx_empty;
    logic [BYTE_W-1:0] w_tx_head;
    logic              w_rx_push;
    logic              w_rx_full;

    spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (wr_en_i),
        .data_i  (wr_data_i),
        .pop_i   (w_tx_pop),
        .data_o  (w_tx_head),
        .full_o  (tx_full_o),
        .empty_o (w_tx_empty)
    );

    spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_rx_push),
        .data_i  (spi_dout_i),
        .pop_i   (rd_en_i),
        .data_o  (rd_data_o),
        .full_o  (w_rx_full),
        .empty_o (rx_empty_o)
    );

    // Next-state, counter and registered-output computation.
    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_ss_n_nxt   = r_ss_n;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_ovf_nxt    = r_ovf;
        w_din_nxt    = r_din;
        w_start_nxt  = 1'b0;
        w_tx_pop     = 1'b0;
        w_rx_push    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ss_n_nxt = 1'b1;
                w_busy_nxt = 1'b0;
                if (go_i) begin
                    w_ovf_nxt = 1'b0;
                    if (len_i != 8'd0) begin
                        w_rem_nxt    = len_i;
                        w_cnt_nxt    = CNT_W'(SS_SETUP);
                        w_ss_n_nxt   = 1'b0;
                        w_busy_nxt   = 1'b1;
                        w_next_state = SETUP;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            SETUP: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt    = '0;
                    w_next_state = WAIT_TX;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            WAIT_TX: begin
                if (!w_tx_empty && spi_ready_i) begin
                    w_tx_pop     = 1'b1;
                    w_din_nxt    = w_tx_head;
                    w_start_nxt  = 1'b1;
                    w_next_state = XFER;
                end else begin
                    w_next_state = WAIT_TX;
                end
            end
            XFER: begin
                if (spi_done_tick_i) begin
                    w_rx_push = 1'b1;
                    // A host pop in the same cycle makes room, so only an unpopped full RX drops.
                    if (w_rx_full && !rd_en_i) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_ovf_nxt = r_ovf;
                    end
                    w_rem_nxt = r_rem - 8'd1;
                    if (r_rem == 8'd1) begin
                        w_cnt_nxt    = CNT_W'(SS_HOLD);
                        w_next_state = HOLD;
                    end else begin
                        w_next_state = WAIT_TX;
                    end
                end else begin
                    w_next_state = XFER;
                end
            end
            HOLD: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt    = '0;
                    w_ss_n_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_ss_n_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_ss_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_din   <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_ss_n  <= w_ss_n_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ovf   <= w_ovf_nxt;
            r_din   <= w_din_nxt;
            r_start <= w_start_nxt;
        end
    end

    assign ss_n_o       = r_ss_n;
    assign busy_o       = r_busy;
    assign burst_done_o = r_done;
    assign rx_ovf_o     = r_ovf;
    assign spi_din_o    = r_din;
    assign spi_start_o  = r_start;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Randomized scoreboard bench for spi_burst_ctrl with a queue-based reference
// model and a simple echoing SPI master model.
module tb_spi_burst_ctrl;

    localparam int DEPTH    = 8;
    localparam int SS_SETUP = 2;
    localparam int SS_HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en, go, spi_ready, spi_tick;
    logic [7:0] wr_data, len, spi_dout;
    logic       tx_full, rx_empty, busy, done, ovf, start, ss_n;
    logic [7:0] rd_data, din;

    always #5 clk = ~clk;

    spi_burst_ctrl #(.DEPTH(DEPTH), .SS_SETUP(SS_SETUP), .SS_HOLD(SS_HOLD)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_data_i(wr_data), .tx_full_o(tx_full),
        .rd_en_i(rd_en), .rd_data_o(rd_data), .rx_empty_o(rx_empty),
        .go_i(go), .len_i(len), .busy_o(busy), .burst_done_o(done), .rx_ovf_o(ovf),
        .spi_din_o(din), .spi_start_o(start), .spi_ready_i(spi_ready),
        .spi_done_tick_i(spi_tick), .spi_dout_i(spi_dout), .ss_n_o(ss_n)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    bit  m_busy = 1'b0;
    bit  in_xfer = 1'b0;
    bit  exp_ovf = 1'b0;
    int  m_rem, go_edge, done_edge = -1, starts, b_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor and scoreboard: samples inputs at the edge, outputs 1ns later.
    initial begin
        bit c_rst, c_go, c_tick, c_rd, c_wr, exp_done;
        logic [7:0] c_len, c_dout, c_wdata, exp_b;
        forever begin
            @(posedge clk);
            c_rst = rst; c_go = go; c_len = len; c_tick = spi_tick; c_dout = spi_dout;
            c_rd = rd_en; c_wr = wr_en; c_wdata = wr_data;
            #1;
            cyc++;
            exp_done = 1'b0;
            if (c_rst) begin
                m_tx.delete(); m_rx.delete();
                m_busy = 1'b0; in_xfer = 1'b0; exp_ovf = 1'b0; done_edge = -1;
                chk("rst_start", start, 1'b0);
                chk("rst_din", din, 8'h00);
            end else begin
                if (c_go && !m_busy) begin
                    exp_ovf = 1'b0;
                    if (c_len == 8'd0) begin
                        exp_done = 1'b1;
                    end else begin
                        m_busy = 1'b1; m_rem = c_len; b_len = c_len;
                        go_edge = cyc; starts = 0; done_edge = -1;
                    end
                end
                if (m_busy && cyc == done_edge) begin
                    exp_done = 1'b1;
                    m_busy = 1'b0;
                    chk("start_count", starts, b_len);
                end
                if (c_tick && in_xfer) begin
                    in_xfer = 1'b0;
                    if (c_rd && m_rx.size() > 0) void'(m_rx.pop_front());
                    if (m_rx.size() < DEPTH) m_rx.push_back(c_dout);
                    else exp_ovf = 1'b1;
                    m_rem--;
                    if (m_rem == 0) done_edge = cyc + SS_HOLD;
                end else if (c_rd && m_rx.size() > 0) begin
                    void'(m_rx.pop_front());
                end
                if (start) begin
                    chk("start_in_burst", {m_busy, in_xfer}, 2'b10);
                    chk("ss_setup_ok", (cyc - go_edge) >= SS_SETUP, 1'b1);
                    chk("start_tx_avail", m_tx.size() > 0, 1'b1);
                    if (m_tx.size() > 0) begin
                        exp_b = m_tx.pop_front();
                        chk("spi_din", din, exp_b);
                    end
                    in_xfer = 1'b1;
                    starts++;
                end
                if (c_wr && m_tx.size() < DEPTH) m_tx.push_back(c_wdata);
            end
            chk("burst_done", done, exp_done);
            chk("busy", busy, m_busy);
            chk("ss_n", ss_n, !m_busy);
            chk("rx_ovf", ovf, exp_ovf);
            chk("tx_full", tx_full, m_tx.size() == DEPTH);
            chk("rx_empty", rx_empty, m_rx.size() == 0);
            if (m_rx.size() > 0) chk("rd_data", rd_data, m_rx[0]);
        end
    end

    // SPI master model: echoes the inverted byte after a random latency.
    initial begin
        logic [7:0] cap;
        int lat;
        spi_ready = 1'b1; spi_tick = 1'b0; spi_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (start === 1'b1) begin
                cap = din; spi_ready = 1'b0;
                lat = $urandom_range(1, 4);
                repeat (lat) @(negedge clk);
                spi_dout = ~cap; spi_tick = 1'b1;
                @(negedge clk);
                spi_tick = 1'b0; spi_ready = 1'b1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk); wr_en = 1'b1; wr_data = b;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic start_burst(input logic [7:0] l);
        @(negedge clk); go = 1'b1; len = l;
        @(negedge clk); go = 1'b0;
    endtask

    task automatic pop1();
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while (m_busy && n < maxc) begin @(negedge clk); n++; end
        chk(name, m_busy, 1'b0);
    endtask

    task automatic wait_xfer(input int maxc);
        int n = 0;
        while (!in_xfer && n < maxc) begin @(negedge clk); n++; end
        chk("xfer_reached", in_xfer, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (!rx_empty && n < 4 * DEPTH) begin pop1(); n++; end
    endtask

    // Watchdog for a run that stops making progress.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by randomized bursts.
    initial begin
        int extra, rem_push, n;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; go = 1'b0; wr_data = 8'h00; len = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic two-byte burst with echoed data
        push(8'hA5); push(8'h3C);
        start_burst(8'd2);
        wait_idle("t1_done", 200);
        chk("t1_rx0", rd_data, 8'h5A);
        pop1();
        chk("t1_rx1", rd_data, 8'hC3);
        pop1();

        // Zero-length burst is a no-op with a done pulse
        start_burst(8'd0);
        repeat (3) @(negedge clk);

        // TX underrun stall, then refill
        push(8'h11);
        start_burst(8'd3);
        repeat (20) @(negedge clk);
        chk("t3_stall_busy", busy, 1'b1);
        chk("t3_stall_ss", ss_n, 1'b0);
        push(8'h22); push(8'h33);
        wait_idle("t3_done", 300);

        // TX overfill and RX overflow
        drain();
        for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
        chk("t4_tx_full", tx_full, 1'b1);
        start_burst(8'd10);
        extra = 0; n = 0;
        while (m_busy && n < 2000) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (extra < 2 && !tx_full) begin
                wr_en = 1'b1; wr_data = 8'hE0 + 8'(extra); extra++;
            end
            n++;
        end
        @(negedge clk); wr_en = 1'b0;
        chk("t4_done", m_busy, 1'b0);
        chk("t4_ovf_set", ovf, 1'b1);
        start_burst(8'd0);
        chk("t4_ovf_clear", ovf, 1'b0);
        drain();

        // Reset in the middle of a transfer
        push(8'h01); push(8'h02); push(8'h03);
        start_burst(8'd3);
        wait_xfer(100);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("t5_ss_n", ss_n, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_start", start, 1'b0);
        chk("t5_rx_empty", rx_empty, 1'b1);
        chk("t5_tx_full", tx_full, 1'b0);
        repeat (10) @(negedge clk);
        chk("t5_late_tick", rx_empty, 1'b1);

        // go while busy is ignored
        push(8'h77); push(8'h88); push(8'h99);
        start_burst(8'd3);
        wait_xfer(100);
        @(negedge clk); go = 1'b1; len = 8'd5;
        @(negedge clk); go = 1'b0;
        wait_idle("t6_done", 300);
        drain();

        // Randomized bursts with concurrent host traffic
        for (int b = 0; b < 25; b++) begin
            int blen, pre;
            blen = $urandom_range(1, 6);
            pre = $urandom_range(0, blen);
            for (int i = 0; i < pre; i++) push(8'($urandom));
            start_burst(8'(blen));
            rem_push = blen - pre; n = 0;
            forever begin
                @(negedge clk);
                wr_en = 1'b0; rd_en = 1'b0; go = 1'b0;
                if (!m_busy || n >= 600) break;
                if (rem_push > 0 && !tx_full && ($urandom % 3) == 0) begin
                    wr_en = 1'b1; wr_data = 8'($urandom); rem_push--;
                end
                rd_en = (($urandom % 4) == 0);
                if (($urandom % 16) == 0) begin
                    go = 1'b1; len = 8'($urandom_range(1, 6));
                end
                n++;
            end
            chk("rand_done", m_busy, 1'b0);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_burst_ctrl.md
Name: spi_burst_ctrl

Overview:
Burst controller that sits directly upstream of the SPI master core. It buffers outgoing bytes in a TX FIFO and issues them to the SPI master through its din/start/ready handshake. It collects each received byte (dout on spi_done_tick) into an RX FIFO and frames the whole burst with an active-low slave select. Host logic pushes and pops bytes and launches a burst of len_i bytes with a single go_i pulse.

Parameters:
DEPTH, 8, entries per FIFO (power of 2, >=2)
SS_SETUP, 2, clk cycles between ss_n_o falling and first possible spi_start_o
SS_HOLD, 2, clk cycles between last spi_done_tick_i and ss_n_o rising

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous, active-high reset
wr_en_i  in  1  push wr_data_i into TX FIFO
wr_data_i  in  8  TX byte
tx_full_o  out  1  TX FIFO full
rd_en_i  in  1  pop RX FIFO
rd_data_o  out  8  RX head byte (show-ahead)
rx_empty_o  out  1  RX FIFO empty
go_i  in  1  start burst (sampled only in IDLE)
len_i  in  8  burst length in bytes; 0 = no-op
busy_o  out  1  burst in progress
burst_done_o  out  1  one-cycle pulse at burst end
rx_ovf_o  out  1  sticky: RX byte dropped because RX full
spi_din_o  out  8  byte to SPI master
spi_start_o  out  1  one-cycle start pulse to SPI master
spi_ready_i  in  1  SPI master idle
spi_done_tick_i  in  1  SPI master byte complete
spi_dout_i  in  8  byte received by SPI master
ss_n_o  out  1  slave select, active low

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: ss_n_o=1; spi_start_o=0; spi_din_o=0; busy_o=0; burst_done_o=0; rx_ovf_o=0; both FIFOs empty (tx_full_o=0, rx_empty_o=1). Reset mid-burst aborts immediately. No further start pulse is issued, and ss_n_o=1 on the cycle after rst_i is sampled.
- All outputs are registered except rd_data_o, tx_full_o and rx_empty_o, which are direct FIFO status/head.
- FIFOs:
  - Push when full is ignored. Pop when empty is ignored.
  - Simultaneous push and pop is allowed in any state (TX: host push + internal pop; RX: internal push + host pop).
  - On RX, a simultaneous push and pop while full counts as a pop first, so the push succeeds.
- State machine: IDLE, SETUP, WAIT_TX, XFER, HOLD.
- IDLE:
  - ss_n_o=1, busy_o=0.
  - go_i with len_i!=0: latch remaining<=len_i, clear rx_ovf_o, load counter with SS_SETUP, set ss_n_o=0, busy_o=1, go to SETUP.
  - go_i with len_i==0: clear rx_ovf_o, pulse burst_done_o next cycle, stay in IDLE, ss_n_o stays 1.
- SETUP: decrement counter; on reaching 0, go to WAIT_TX. ss_n_o=0 for at least SS_SETUP cycles before any start.
- WAIT_TX:
  - When TX is not empty and spi_ready_i=1: pop TX, register spi_din_o<=TX head, register spi_start_o<=1, go to XFER.
  - spi_start_o is high for exactly the first XFER cycle; spi_din_o is held stable until the next issue.
  - If TX stays empty, stall indefinitely with ss_n_o=0 (no timeout).
- XFER:
  - Wait for spi_done_tick_i.
  - On the tick: push spi_dout_i into RX; if RX is full and not popped that cycle, drop the byte and set rx_ovf_o=1.
  - Then decrement remaining. If the old remaining was 1, load counter with SS_HOLD and go to HOLD; otherwise go to WAIT_TX.
- HOLD: ss_n_o stays 0; count SS_HOLD cycles, then set ss_n_o=1, busy_o=0, pulse burst_done_o for one cycle, and return to IDLE.
- spi_done_tick_i outside XFER is ignored. go_i while busy_o=1 is ignored.
- Back-to-back: a new go_i in the cycle after burst_done_o is accepted. ss_n_o is high for at least 1 cycle between bursts.

Decomposition:
- Package spi_ctrl_pkg holds:
  - BYTE_W=8
  - state enum state_t {IDLE, SETUP, WAIT_TX, XFER, HOLD}
  - default SS_SETUP/SS_HOLD constants
- Sub-module spi_sync_fifo (parameters WIDTH, DEPTH; show-ahead; full/empty flags; one extra pointer bit for wrap), instantiated twice: TX and RX.
- The FSM, counters and SPI handshake live in spi_burst_ctrl.

Test Plan:
1. Push 0xA5, 0x3C; go_i with len_i=2; SPI model echoes ~din (0x5A, 0xC3) -> ss_n_o low, then spi_start_o pulses with spi_din_o=0xA5 then 0x3C. RX pops 0x5A, 0xC3. ss_n_o rises SS_HOLD cycles after the second done tick, together with a single burst_done_o pulse.
2. go_i with len_i=0 -> burst_done_o high for 1 cycle the next cycle; ss_n_o=1 throughout; no spi_start_o.
3. One byte in TX, go_i with len_i=3 -> one transfer, then stall in WAIT_TX with ss_n_o=0 and busy_o=1. Push 2 bytes 20 cycles later -> remaining 2 transfers complete; burst_done_o pulses once.
4. DEPTH=8; push 10 bytes (8 accepted, tx_full_o=1, further pushes ignored while full); go_i with len_i=10; refill TX as space frees; no RX reads -> RX holds the first 8 echoes, rx_ovf_o=1. The next go_i clears rx_ovf_o.
5. rst_i asserted for 1 cycle during XFER -> next cycle ss_n_o=1, busy_o=0, spi_start_o=0, rx_empty_o=1, tx_full_o=0. A late spi_done_tick_i pushes nothing.
6. go_i pulsed again during XFER with len_i=5 -> ignored. The burst completes with the original length, and exactly len_i start pulses are observed.
